// File: rtl/drop_sequencer.sv
// ============================================================================
// drop_sequencer : spawn / fall / collision-check / lock / line-clear sequencer
//                  for the active piece. Sole owner of the checker Enable.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module drop_sequencer #(
    parameter int SPAWN_X     = 6,
    parameter int FLOOR_Y     = 16,
    parameter int SOFT_PERIOD = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       start,
    input  logic       gravityTick,
    input  logic       softDrop,
    input  logic [3:0] nextBlock,
    input  logic       canMove,
    input  logic       clearDone,
    output logic       checkEn,
    output logic [3:0] currentBlock,
    output logic [3:0] XPOS,
    output logic [4:0] YPOS,
    output logic       lockPiece,
    output logic       clearReq,
    output logic       gameOver,
    output logic [7:0] pieceCount
);

    localparam int CNT_W = (SOFT_PERIOD > 2) ? $clog2(SOFT_PERIOD) : 1;

    localparam logic [CNT_W-1:0] c_soft_last = CNT_W'(SOFT_PERIOD - 1);
    localparam logic [3:0]       c_spawn_x   = 4'(SPAWN_X);
    localparam logic [4:0]       c_floor_y   = 5'(FLOOR_Y);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_FALL   = 3'd2,
        S_CHECK  = 3'd3,
        S_RESULT = 3'd4,
        S_LOCK   = 3'd5,
        S_CLEAR  = 3'd6,
        S_OVER   = 3'd7
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic             check_en_q;
    logic [3:0]       block_q;
    logic [3:0]       xpos_q;
    logic [4:0]       ypos_q;
    logic             lock_q;
    logic             clear_req_q;
    logic             game_over_q;
    logic [7:0]       piece_cnt_q;
    logic             w_fall_req;

    // A gravity tick and a soft-drop step in the same cycle collapse into one request.
    assign w_fall_req = gravityTick | (softDrop & (drop_cnt_q == c_soft_last));

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            drop_cnt_q  <= '0;
            check_en_q  <= 1'b0;
            block_q     <= 4'd0;
            xpos_q      <= c_spawn_x;
            ypos_q      <= 5'd0;
            lock_q      <= 1'b0;
            clear_req_q <= 1'b0;
            game_over_q <= 1'b0;
            piece_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        piece_cnt_q <= 8'd0;
                        state_q     <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    block_q    <= (nextBlock == 4'd15) ? 4'd0 : nextBlock;
                    xpos_q     <= c_spawn_x;
                    ypos_q     <= 5'd0;
                    drop_cnt_q <= '0;
                    state_q    <= S_FALL;
                end
                S_FALL: begin
                    if (!softDrop) begin
                        drop_cnt_q <= '0;
                    end else if (drop_cnt_q == c_soft_last) begin
                        drop_cnt_q <= '0;
                    end else begin
                        drop_cnt_q <= drop_cnt_q + 1'b1;
                    end
                    // The checker indexes row YPOS+4, so it must never be enabled at the floor.
                    if (w_fall_req) begin
                        if (ypos_q == c_floor_y) begin
                            lock_q  <= 1'b1;
                            state_q <= S_LOCK;
                        end else begin
                            check_en_q <= 1'b1;
                            state_q    <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    check_en_q <= 1'b0;
                    state_q    <= S_RESULT;
                end
                S_RESULT: begin
                    if (canMove) begin
                        ypos_q     <= ypos_q + 5'd1;
                        drop_cnt_q <= '0;
                        state_q    <= S_FALL;
                    end else begin
                        lock_q  <= 1'b1;
                        state_q <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    lock_q      <= 1'b0;
                    piece_cnt_q <= piece_cnt_q + 8'd1;
                    if (ypos_q == 5'd0) begin
                        game_over_q <= 1'b1;
                        state_q     <= S_OVER;
                    end else begin
                        clear_req_q <= 1'b1;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clearDone) begin
                        clear_req_q <= 1'b0;
                        state_q     <= S_SPAWN;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        game_over_q <= 1'b0;
                        piece_cnt_q <= 8'd0;
                        state_q     <= S_SPAWN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign checkEn      = check_en_q;
    assign currentBlock = block_q;
    assign XPOS         = xpos_q;
    assign YPOS         = ypos_q;
    assign lockPiece    = lock_q;
    assign clearReq     = clear_req_q;
    assign gameOver     = game_over_q;
    assign pieceCount   = piece_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_drop_sequencer.sv
// ============================================================================
// tb_drop_sequencer : scoreboard bench for drop_sequencer (event queue + monitor)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_drop_sequencer;

    localparam int K_CHK  = 0;
    localparam int K_LOCK = 1;
    localparam int K_CLR  = 2;
    localparam int K_STEP = 3;
    localparam int K_GO   = 4;

    typedef struct {
        int kind;
        int y;
        int blk;
        int x;
        int cnt;
    } ev_t;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       start = 1'b0;
    logic       gravityTick = 1'b0;
    logic       softDrop = 1'b0;
    logic [3:0] nextBlock = 4'd2;
    logic       canMove;
    logic       clearDone = 1'b0;
    logic       checkEn;
    logic [3:0] currentBlock;
    logic [3:0] XPOS;
    logic [4:0] YPOS;
    logic       lockPiece;
    logic       clearReq;
    logic       gameOver;
    logic [7:0] pieceCount;

    logic       cm = 1'b1;
    logic       auto_mode = 1'b0;
    logic       mon_en = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    ev_t exp_q[$];

    // In auto mode the piece may fall once from the spawn row and is then blocked.
    assign canMove = auto_mode ? (YPOS == 5'd0) : cm;

    always #5 Clock = ~Clock;

    drop_sequencer #(.SPAWN_X(6), .FLOOR_Y(16), .SOFT_PERIOD(4)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .gravityTick(gravityTick),
        .softDrop(softDrop), .nextBlock(nextBlock), .canMove(canMove), .clearDone(clearDone),
        .checkEn(checkEn), .currentBlock(currentBlock), .XPOS(XPOS), .YPOS(YPOS),
        .lockPiece(lockPiece), .clearReq(clearReq), .gameOver(gameOver), .pieceCount(pieceCount)
    );

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    task automatic push(input int kind, input int y, input int blk, input int x, input int cnt);
        ev_t e;
        e.kind = kind; e.y = y; e.blk = blk; e.x = x; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int y, input int blk, input int x, input int cnt);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d y=%0d blk=%0d x=%0d cnt=%0d expected none (t=%0t)",
                     kind, y, blk, x, cnt, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.y == y && e.blk == blk && e.x == x && e.cnt == cnt) n_pass++;
            else $display("FAIL event: got kind=%0d y=%0d blk=%0d x=%0d cnt=%0d expected kind=%0d y=%0d blk=%0d x=%0d cnt=%0d (t=%0t)",
                          kind, y, blk, x, cnt, e.kind, e.y, e.blk, e.x, e.cnt, $time);
        end
    endtask

    // Monitor: turns visible DUT activity into events and scores them against the queue.
    logic [4:0] prev_y = 5'd0;
    logic [3:0] prev_blk = 4'd0;
    logic       prev_clr = 1'b0;
    logic       prev_go = 1'b0;

    always @(negedge Clock) begin
        if (mon_en) begin
            if (checkEn) observe(K_CHK, int'(YPOS), int'(currentBlock), 0, 0);
            if (lockPiece) observe(K_LOCK, int'(YPOS), int'(currentBlock), 0, int'(pieceCount));
            if (clearReq != prev_clr) observe(K_CLR, int'(clearReq), 0, 0, 0);
            if (YPOS != prev_y || currentBlock != prev_blk)
                observe(K_STEP, int'(YPOS), int'(currentBlock), int'(XPOS), 0);
            if (gameOver != prev_go) observe(K_GO, int'(gameOver), 0, 0, 0);
        end
        prev_y   = YPOS;
        prev_blk = currentBlock;
        prev_clr = clearReq;
        prev_go  = gameOver;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Holds gravityTick for w edges; returns 1 time unit after the first sampling edge + (w-1).
    task automatic do_tick(input int w);
        gravityTick = 1'b1;
        cyc(w);
        gravityTick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear_done();
        clearDone = 1'b1;
        cyc(1);
        clearDone = 1'b0;
    endtask

    initial begin
        int locks;
        int budget;

        // ---------------- reset values ----------------
        cyc(3);
        chk("rst_xpos", int'(XPOS), 6);
        chk("rst_ypos", int'(YPOS), 0);
        chk("rst_block", int'(currentBlock), 0);
        chk("rst_count", int'(pieceCount), 0);
        chk("rst_ctrl", int'({checkEn, lockPiece, clearReq, gameOver}), 0);
        Resetn = 1'b1;
        mon_en = 1'b1;

        // ---------------- free fall to the floor ----------------
        push(K_STEP, 0, 2, 6, 0);
        pulse_start();
        cyc(4);
        for (int y = 0; y < 16; y++) begin
            push(K_CHK, y, 2, 0, 0);
            push(K_STEP, y + 1, 2, 6, 0);
            if (y == 0) begin
                do_tick(1);
                chk("fall_checken_n1", int'(checkEn), 1);
                cyc(1);
                chk("fall_ypos_n1", int'(YPOS), 0);
                chk("fall_checken_n2", int'(checkEn), 0);
                cyc(1);
                chk("fall_ypos_n2", int'(YPOS), 1);
                cyc(8);
            end else if (y == 1) begin
                do_tick(3);
                cyc(7);
            end else begin
                do_tick(1);
                cyc(9);
            end
        end
        chk("floor_ypos", int'(YPOS), 16);
        push(K_LOCK, 16, 2, 0, 0);
        push(K_CLR, 1, 0, 0, 0);
        do_tick(1);
        chk("floor_lock_n1", int'(lockPiece), 1);
        chk("floor_no_check", int'(checkEn), 0);
        cyc(1);
        chk("floor_count", int'(pieceCount), 1);
        chk("floor_clearreq", int'(clearReq), 1);
        do_tick(1);
        cyc(2);
        nextBlock = 4'd15;
        push(K_CLR, 0, 0, 0, 0);
        push(K_STEP, 0, 0, 6, 0);
        pulse_clear_done();
        cyc(3);

        // ---------------- blocked fall at row 5 ----------------
        for (int y = 0; y < 5; y++) begin
            push(K_CHK, y, 0, 0, 0);
            push(K_STEP, y + 1, 0, 6, 0);
            do_tick(1);
            cyc(5);
        end
        cm = 1'b0;
        push(K_CHK, 5, 0, 0, 0);
        push(K_LOCK, 5, 0, 0, 1);
        push(K_CLR, 1, 0, 0, 0);
        do_tick(1);
        cyc(2);
        chk("block_lock", int'(lockPiece), 1);
        chk("block_ypos", int'(YPOS), 5);
        cyc(1);
        chk("block_clearreq", int'(clearReq), 1);
        do_tick(1);
        cyc(3);
        chk("block_ypos_clear", int'(YPOS), 5);
        nextBlock = 4'd7;
        cm = 1'b1;
        push(K_CLR, 0, 0, 0, 0);
        push(K_STEP, 0, 7, 6, 0);
        pulse_clear_done();
        cyc(3);

        // ---------------- soft drop ----------------
        push(K_CHK, 0, 7, 0, 0);
        push(K_STEP, 1, 7, 6, 0);
        push(K_CHK, 1, 7, 0, 0);
        push(K_STEP, 2, 7, 6, 0);
        softDrop = 1'b1;
        cyc(5);
        chk("soft_ypos_s5", int'(YPOS), 0);
        cyc(1);
        chk("soft_ypos_s6", int'(YPOS), 1);
        cyc(6);
        chk("soft_ypos_s12", int'(YPOS), 2);
        cyc(2);
        softDrop = 1'b0;
        cyc(2);
        push(K_CHK, 2, 7, 0, 0);
        push(K_STEP, 3, 7, 6, 0);
        softDrop = 1'b1;
        cyc(5);
        chk("soft_release_t5", int'(YPOS), 2);
        cyc(1);
        chk("soft_release_t6", int'(YPOS), 3);
        softDrop = 1'b0;
        cyc(3);

        // ---------------- game over ----------------
        cm = 1'b0;
        push(K_CHK, 3, 7, 0, 0);
        push(K_LOCK, 3, 7, 0, 2);
        push(K_CLR, 1, 0, 0, 0);
        do_tick(1);
        cyc(3);
        nextBlock = 4'd9;
        push(K_CLR, 0, 0, 0, 0);
        push(K_STEP, 0, 9, 6, 0);
        pulse_clear_done();
        cyc(3);
        push(K_CHK, 0, 9, 0, 0);
        push(K_LOCK, 0, 9, 0, 3);
        push(K_GO, 1, 0, 0, 0);
        do_tick(1);
        cyc(3);
        chk("over_gameover", int'(gameOver), 1);
        chk("over_count", int'(pieceCount), 4);
        chk("over_no_clear", int'(clearReq), 0);
        do_tick(1);
        cyc(3);
        chk("over_frozen_y", int'(YPOS), 0);
        chk("over_frozen_blk", int'(currentBlock), 9);
        nextBlock = 4'd3;
        push(K_GO, 0, 0, 0, 0);
        push(K_STEP, 0, 3, 6, 0);
        pulse_start();
        chk("restart_count", int'(pieceCount), 0);
        chk("restart_gameover", int'(gameOver), 0);
        cyc(2);

        // ---------------- 256 locks wrap the piece counter ----------------
        for (int k = 0; k < 256; k++) begin
            push(K_CHK, 0, 3, 0, 0);
            push(K_STEP, 1, 3, 6, 0);
            push(K_CHK, 1, 3, 0, 0);
            push(K_LOCK, 1, 3, 0, k);
            push(K_CLR, 1, 0, 0, 0);
            push(K_CLR, 0, 0, 0, 0);
            push(K_STEP, 0, 3, 6, 0);
        end
        auto_mode = 1'b1;
        clearDone = 1'b1;
        gravityTick = 1'b1;
        locks = 0;
        while (locks < 256) begin
            budget = 0;
            while (!lockPiece && budget < 20) begin
                cyc(1);
                budget++;
            end
            if (!lockPiece) begin
                chk("wrap_lock_timeout", locks, 256);
                break;
            end
            locks++;
            if (locks == 256) gravityTick = 1'b0;
            cyc(1);
        end
        gravityTick = 1'b0;
        cyc(5);
        chk("wrap_count", int'(pieceCount), 0);
        clearDone = 1'b0;
        auto_mode = 1'b0;

        // ---------------- reset mid-CLEAR ----------------
        cm = 1'b1;
        push(K_CHK, 0, 3, 0, 0);
        push(K_STEP, 1, 3, 6, 0);
        do_tick(1);
        cyc(3);
        cm = 1'b0;
        push(K_CHK, 1, 3, 0, 0);
        push(K_LOCK, 1, 3, 0, 0);
        push(K_CLR, 1, 0, 0, 0);
        do_tick(1);
        cyc(4);
        chk("preclear_clearreq", int'(clearReq), 1);
        chk("pending_events", exp_q.size(), 0);
        mon_en = 1'b0;
        Resetn = 1'b0;
        cyc(1);
        chk("rst_clearreq_drop", int'(clearReq), 0);
        cyc(1);
        Resetn = 1'b1;
        chk("rst2_xpos", int'(XPOS), 6);
        chk("rst2_ypos", int'(YPOS), 0);
        chk("rst2_gameover", int'(gameOver), 0);
        chk("rst2_count", int'(pieceCount), 0);
        mon_en = 1'b1;
        // In IDLE a tick and a clearDone must be ignored; only start leaves.
        do_tick(1);
        cyc(3);
        pulse_clear_done();
        cyc(2);
        nextBlock = 4'd4;
        push(K_STEP, 0, 4, 6, 0);
        pulse_start();
        cyc(4);
        chk("final_pending_events", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/drop_sequencer.md
# drop_sequencer

Sequences a falling piece's life cycle: spawn, gravity and soft-drop stepping, a one-row-below collision check, lock, then a line-clear handshake. It sits between the game timing (gravity tick, buttons) and the board-side blocks: the registered down-collision checker, the board writer and the line-clear engine. It owns the active piece's currentBlock, XPOS and YPOS registers. It is the only block allowed to pulse the checker's Enable.

## Interface
- SPAWN_X, 6: XPOS loaded at spawn.
- FLOOR_Y, 16: YPOS at which the piece box rests on the board floor. The checker indexes row YPOS+4, so it is never enabled at FLOOR_Y.
- SOFT_PERIOD, 4: cycles per soft-drop step while softDrop is held (≥2).
- Clock  in  1  system clock; all state changes on posedge.
- Resetn  in  1  synchronous, active-low reset.
- start  in  1  begin a game; sampled in IDLE and OVER only.
- gravityTick  in  1  one-cycle fall request.
- softDrop  in  1  level; requests a fall every SOFT_PERIOD cycles.
- nextBlock  in  4  piece code for the next spawn, 0–14; value 15 spawns as 0.
- canMove  in  1  registered checker result, valid the cycle after checkEn.
- clearDone  in  1  line-clear engine finished; meaningful only in CLEAR.
- checkEn  out  1  checker Enable; high exactly one cycle per check.
- currentBlock  out  4  active piece code.
- XPOS  out  4  active piece column.
- YPOS  out  5  active piece row.
- lockPiece  out  1  one-cycle pulse; the board writer commits the piece.
- clearReq  out  1  held high until clearDone is sampled.
- gameOver  out  1  high while in OVER.
- pieceCount  out  8  pieces locked this game.

## Operation
- States: IDLE, SPAWN, FALL, CHECK, RESULT, LOCK, CLEAR, OVER. All outputs are registered.
- Reset values: state IDLE, currentBlock 0, XPOS SPAWN_X, YPOS 0, all pulse and level outputs 0, pieceCount 0, dropCnt 0.
- IDLE: start=1 → SPAWN, and pieceCount←0.
- SPAWN (1 cycle):
  - currentBlock←nextBlock (15→0), XPOS←SPAWN_X, YPOS←0, dropCnt←0.
  - Next state: FALL.
- FALL:
  - dropCnt increments while softDrop=1 and wraps at SOFT_PERIOD−1. It clears to 0 when softDrop=0.
  - fallReq = gravityTick | (softDrop & dropCnt==SOFT_PERIOD−1).
  - On fallReq with YPOS==FLOOR_Y → LOCK.
  - On fallReq with any other YPOS → CHECK, with checkEn←1.
- CHECK (1 cycle, checkEn=1): the checker samples its inputs at the closing edge. Next state: RESULT, with checkEn←0.
- RESULT:
  - canMove=1 → YPOS←YPOS+1, dropCnt←0, next FALL.
  - canMove=0 → LOCK.
- LOCK (1 cycle, lockPiece=1): pieceCount←pieceCount+1, wrapping 255→0.
  - If YPOS==0 → OVER. The piece could not fall from spawn.
  - Otherwise → CLEAR, with clearReq←1.
- CLEAR: clearReq stays 1. When clearDone=1: clearReq←0 and go to SPAWN.
- OVER: gameOver=1 and the piece registers are frozen. start=1 → gameOver←0, pieceCount←0, go to SPAWN.
- currentBlock, XPOS and YPOS change only in SPAWN and RESULT. They are stable from CHECK through the end of LOCK.
- Ignored inputs:
  - gravityTick and softDrop outside FALL; requests are not queued.
  - clearDone outside CLEAR.
  - start outside IDLE and OVER.
- Simultaneous gravityTick and soft-drop step in one cycle produce one fall request.
- YPOS never exceeds FLOOR_Y. Increment occurs only after a check, and no check is issued at FLOOR_Y.

## Timing
- Fall request sampled at edge N:
  - checkEn high during cycle N..N+1.
  - canMove read in cycle N+1..N+2.
  - YPOS updated (or LOCK entered) at edge N+2.
- Minimum spacing between two successful falls: 3 cycles.
- Floor case: request at edge N puts lockPiece high during cycle N..N+1.
- Lock at edge L (cycle L..L+1):
  - clearReq rises at edge L+1.
  - clearDone sampled at edge C → clearReq low and SPAWN at C; FALL at C+1.
  - clearDone high in the same cycle clearReq first asserts is accepted.
- Resetn=0 at any edge forces all reset values at that edge, including mid-CHECK and mid-CLEAR. clearReq and checkEn drop immediately.

## Test plan
- Reset: hold Resetn=0 for 2 edges mid-CLEAR → clearReq=0, state IDLE, XPOS=6, YPOS=0, gameOver=0.
- Free fall:
  - Stimulus: start, nextBlock=2, canMove tied 1, gravityTick every 10 cycles.
  - Response: YPOS steps 0→16 two edges after each tick; one checkEn pulse per tick.
  - At YPOS=16 the next tick gives lockPiece two cycles earlier, one edge after the tick, with no checkEn.
- Blocked fall: YPOS=5, canMove=0 at check → lockPiece one cycle, YPOS stays 5, clearReq high until clearDone pulse, then spawn with YPOS=0.
- Soft drop: softDrop held, gravityTick=0, canMove=1 → YPOS increments every SOFT_PERIOD+2 cycles. Release mid-count → counter clears, no step.
- Game over:
  - Stimulus: spawn, first check returns canMove=0.
  - Response: lockPiece pulse, gameOver=1, pieceCount=1, ticks ignored.
  - Then start → gameOver=0, pieceCount=0, new spawn.
- Edge inputs:
  - nextBlock=15 spawns currentBlock=0.
  - gravityTick during CHECK or CLEAR is ignored: YPOS changes only once.
  - 256 locks wrap pieceCount to 0.
